// File: rtl/phoenix_console_pkg.sv
// Shared encodings for the phoeniX console UART: FSM states, register offsets, STATUS bit map.
// No logic here; latency and backpressure are defined by the modules that import it.
package phoenix_console_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Bus direction encodings shared with the core's data memory interface
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam logic [31:0] TXDATA_OFFSET = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFFSET = 32'h0000_0004;

    localparam int STATUS_FULL_BIT   = 0;
    localparam int STATUS_EMPTY_BIT  = 1;
    localparam int STATUS_ACTIVE_BIT = 2;
    localparam int STATUS_OVF_BIT    = 3;
    localparam int STATUS_COUNT_LSB  = 8;

endpackage

// File: rtl/phoenix_console_uart_fifo.sv
// Synchronous TX byte FIFO; o_data is the head entry, valid combinationally while not empty.
// Push when full is accepted only alongside a pop; pop when empty is ignored.
module console_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // When full, wr_ptr == rd_ptr: the head is read out before this edge overwrites it
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/phoenix_console_uart.sv
// Console UART on the data memory bus: TXDATA byte pushes are queued and sent LSB-first; start bit 2 edges after write.
// No backpressure: pushes into a full FIFO are dropped and flag sticky overflow; PHOENIX_CONSOLE_PARITY_EN adds even parity.
module phoenix_console_uart
    import phoenix_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_write_data,
    output logic        console_select,
    output logic [31:0] console_read_data,
    output logic        uart_tx
);

    localparam int             CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int             BW          = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    logic          w_hit_tx, w_hit_st, w_wr, w_rd;
    logic          w_push_req, w_push, w_pop, w_status_wr;
    logic          w_full, w_empty;
    logic [7:0]    w_fifo_dat;
    logic [CW-1:0] w_count;
    logic [31:0]   w_status;
    logic          w_unused_bits;

    tx_state_e     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          r_overflow;

    assign w_hit_tx    = (data_memory_interface_address == BASE_ADDRESS + TXDATA_OFFSET);
    assign w_hit_st    = (data_memory_interface_address == BASE_ADDRESS + STATUS_OFFSET);
    assign w_wr        = data_memory_interface_enable && (data_memory_interface_state == MEM_WRITE);
    assign w_rd        = data_memory_interface_enable && (data_memory_interface_state == MEM_READ);
    assign w_push_req  = w_wr && w_hit_tx && data_memory_interface_frame_mask[3];
    assign w_status_wr = w_wr && w_hit_st;
    assign w_pop       = (r_state == ST_IDLE) && !w_empty;
    assign w_push      = w_push_req && (!w_full || w_pop);

    // Only the low byte lane carries TX data
    assign w_unused_bits = ^{data_memory_interface_write_data[31:8], data_memory_interface_frame_mask[2:0]};

    console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (data_memory_interface_write_data[7:0]),
        .o_data  (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_status                                  = '0;
        w_status[STATUS_FULL_BIT]                 = w_full;
        w_status[STATUS_EMPTY_BIT]                = w_empty;
        w_status[STATUS_ACTIVE_BIT]               = (r_state != ST_IDLE);
        w_status[STATUS_OVF_BIT]                  = r_overflow;
        w_status[STATUS_COUNT_LSB +: 8]           = 8'(w_count);
    end

    assign console_select    = data_memory_interface_enable && (w_hit_tx || w_hit_st);
    assign console_read_data = (w_rd && w_hit_st) ? w_status : 32'h0;
    assign uart_tx           = r_tx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
        end else if (w_status_wr) begin
            r_overflow <= 1'b0;
        end
    end

    // r_tx follows the state by one edge, which yields the 2-edge start latency and 1-cycle inter-frame gap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift <= w_fifo_dat;
                        r_baud  <= BAUD_RELOAD;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx <= 1'b0;
                    if (r_baud == '0) begin
                        r_baud    <= BAUD_RELOAD;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                ST_DATA: begin
                    r_tx <= r_shift[r_bit_idx];
                    if (r_baud == '0) begin
                        r_baud <= BAUD_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef PHOENIX_CONSOLE_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
`ifdef PHOENIX_CONSOLE_PARITY_EN
                ST_PARITY: begin
                    r_tx <= ^r_shift;
                    if (r_baud == '0) begin
                        r_baud  <= BAUD_RELOAD;
                        r_state <= ST_STOP;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    r_tx <= 1'b1;
                    if (r_baud == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phoenix_console_uart.sv
// Self-checking bench for phoenix_console_uart: random bus traffic against a byte-queue model and a serial frame decoder.
module tb_phoenix_console_uart;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;
    localparam int          CPB  = 4;
`ifdef PHOENIX_CONSOLE_PARITY_EN
    localparam int          FRAME_BITS = 11;
`else
    localparam int          FRAME_BITS = 10;
`endif
    localparam int          FRAME_CYC = FRAME_BITS * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        st = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  mask = '0;
    logic [31:0] wdata = '0;
    logic        sel;
    logic [31:0] rdata;
    logic        tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int frames = 0;
    bit mon_en = 1'b0;
    bit mon_busy = 1'b0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    phoenix_console_uart #(
        .BASE_ADDRESS (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk                              (clk),
        .reset                            (reset),
        .data_memory_interface_enable     (en),
        .data_memory_interface_state      (st),
        .data_memory_interface_address    (addr),
        .data_memory_interface_frame_mask (mask),
        .data_memory_interface_write_data (wdata),
        .console_select                   (sel),
        .console_read_data                (rdata),
        .uart_tx                          (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Decodes each frame from the line and compares every cycle against the ideal waveform of the next expected byte
    initial begin : frame_monitor
        logic [11:0] fbits;
        logic [7:0]  eb;
        int          bad;
        int          first_bad;
        forever begin
            @(negedge clk);
            if (mon_en && reset === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                start_q.push_back(cyc);
                eb = 8'h00;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: start bit seen at cycle %0d, required idle line", cyc);
                end else begin
                    eb = exp_q.pop_front();
                end
                fbits      = '1;
                fbits[0]   = 1'b0;
                fbits[8:1] = eb;
`ifdef PHOENIX_CONSOLE_PARITY_EN
                fbits[9]   = ^eb;
`endif
                bad = 0; first_bad = 0;
                for (int k = 0; k <= FRAME_CYC; k++) begin
                    if (k > 0) @(negedge clk);
                    if (tx !== fbits[k / CPB]) begin
                        if (bad == 0) first_bad = k;
                        bad++;
                    end
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL frame_%02h: %0d cycles off the required waveform, first at offset %0d", eb, bad, first_bad);
                end
                frames++;
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1);
    end

    task automatic bus_write(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, output logic s);
        @(negedge clk);
        en = 1'b1; st = 1'b1; addr = a; mask = m; wdata = d;
        #1 s = sel;
        @(posedge clk);
        #1 last_wr_cyc = cyc;
        en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic s);
        @(negedge clk);
        en = 1'b1; st = 1'b0; addr = a; mask = 4'h0;
        #1 d = rdata; s = sel;
        en = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc, output bit ok);
        int n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        ok = (n < max_cyc);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d; logic s; int lows = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: line=%b, required 1", tx); end
        reset = 1'b1;
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL reset_status: got %h, required 00000002", d); end
        checks++;
        if (s !== 1'b1) begin errors++; $display("FAIL reset_status_select: got %b, required 1", s); end
        #1;
        checks++;
        if (rdata !== 32'h0 || sel !== 1'b0) begin
            errors++; $display("FAIL idle_bus: rdata=%h sel=%b, required 0 and 0", rdata, sel);
        end
        repeat (20) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        checks++;
        if (lows != 0) begin errors++; $display("FAIL reset_idle_line: %0d non-high cycles, required 0", lows); end
        mon_en = 1'b1;
    endtask

    task automatic test_single_frame();
        logic s; logic [31:0] d; bit ok; int ns;
        ns = start_q.size();
        exp_q.push_back(8'h48);
        bus_write(BASE, 4'b1000, 32'hABCD_EF48, s);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_drain: frame not completed, required 1 frame"); end
        checks++;
        if (start_q.size() != ns + 1 || start_q[ns] != last_wr_cyc + 2) begin
            errors++;
            $display("FAIL single_latency: start at cycle %0d (frames %0d), required cycle %0d",
                     (start_q.size() > ns) ? start_q[ns] : -1, start_q.size() - ns, last_wr_cyc + 2);
        end
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL single_status: got %h, required 00000002", d); end
    endtask

    task automatic test_ignored();
        logic s; logic [31:0] d; int lows = 0; int nf;
        nf = frames;
        bus_write(BASE, 4'b0111, 32'h0000_0055, s);
        checks++;
        if (s !== 1'b1) begin errors++; $display("FAIL ignored_sel_tx: got %b, required 1", s); end
        bus_write(BASE + 32'h8, 4'b1000, 32'h0000_0055, s);
        checks++;
        if (s !== 1'b0) begin errors++; $display("FAIL ignored_sel_plus8: got %b, required 0", s); end
        bus_read(BASE, d, s);
        checks++;
        if (d !== 32'h0 || s !== 1'b1) begin errors++; $display("FAIL txdata_read: data=%h sel=%b, required 0 and 1", d, s); end
        repeat (60) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        checks++;
        if (lows != 0 || frames != nf) begin
            errors++; $display("FAIL ignored_line: %0d low cycles, %0d frames, required 0 and 0", lows, frames - nf);
        end
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL ignored_status: got %h, required 00000002", d); end
    endtask

    task automatic test_overflow();
        logic [7:0] b [18]; logic s; logic [31:0] d; bit ok; int ns; int badgap = 0;
        ns = start_q.size();
        for (int i = 0; i < 18; i++) begin
            b[i] = 8'($urandom);
            if (i < 17) exp_q.push_back(b[i]);
        end
        for (int i = 0; i < 18; i++)
            bus_write(BASE, {1'b1, 3'($urandom)}, {24'($urandom), b[i]}, s);
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_100D) begin errors++; $display("FAIL overflow_status: got %h, required 0000100d", d); end
        bus_write(STAT, 4'($urandom), $urandom, s);
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_1005) begin errors++; $display("FAIL overflow_clear: got %h, required 00001005", d); end
        wait_drain(17 * (FRAME_CYC + 1) + 100, ok);
        checks++;
        if (!ok || start_q.size() != ns + 17) begin
            errors++; $display("FAIL overflow_frames: %0d frames, required 17", start_q.size() - ns);
        end
        for (int i = ns + 1; i < start_q.size(); i++)
            if (start_q[i] - start_q[i-1] != FRAME_CYC + 1) badgap++;
        checks++;
        if (badgap != 0) begin errors++; $display("FAIL back_to_back_gap: %0d gaps wrong, required spacing %0d", badgap, FRAME_CYC + 1); end
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL overflow_final_status: got %h, required 00000002", d); end
    endtask

    task automatic test_random();
        logic [31:0] a, d, wd; logic [3:0] m; logic s, exp_s, is_wr; bit ok; int npush = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = BASE;
                2:       a = STAT;
                3:       a = BASE + 32'h8;
                default: a = BASE + 32'h1;
            endcase
            m = 4'($urandom); wd = $urandom; is_wr = 1'($urandom);
            if (npush >= 12) m[3] = 1'b0;
            exp_s = (a == BASE) || (a == STAT);
            if (is_wr) begin
                if (a == BASE && m[3]) begin exp_q.push_back(wd[7:0]); npush++; end
                bus_write(a, m, wd, s);
            end else begin
                bus_read(a, d, s);
                checks++;
                if ((a != STAT && d !== 32'h0) || (a == STAT && (d & 32'hFFFF_00F8) !== 32'h0)) begin
                    errors++; $display("FAIL random_read_%0d: addr %h data %h, required zero outside STATUS fields", i, a, d);
                end
            end
            checks++;
            if (s !== exp_s) begin errors++; $display("FAIL random_sel_%0d: addr %h sel %b, required %b", i, a, s, exp_s); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_drain(12 * (FRAME_CYC + 1) + 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL random_drain: %0d bytes not sent, required 0", exp_q.size()); end
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL random_status: got %h, required 00000002", d); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] b; logic s; logic [31:0] d; int target; int lows = 0; int nf;
        mon_en = 1'b0;
        b = 8'($urandom) & 8'hF7;
        bus_write(BASE, 4'b1000, {24'h0, b}, s);
        target = last_wr_cyc + 2 + CPB * 4 + 1;
        bus_write(BASE, 4'b1000, $urandom, s);
        bus_write(BASE, 4'b1000, $urandom, s);
        for (int n = 0; n < 100 && cyc < target; n++) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin errors++; $display("FAIL abort_bit3_level: line=%b, required 0", tx); end
        reset = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: line=%b, required 1", tx); end
        @(negedge clk);
        reset = 1'b1;
        bus_read(STAT, d, s);
        checks++;
        if (d !== 32'h0000_0002) begin errors++; $display("FAIL abort_status: got %h, required 00000002", d); end
        nf = frames;
        mon_en = 1'b1;
        repeat (80) begin @(negedge clk); if (tx !== 1'b1) lows++; end
        checks++;
        if (lows != 0 || frames != nf) begin
            errors++; $display("FAIL abort_residual: %0d low cycles, required 0", lows);
        end
    endtask

`ifdef PHOENIX_CONSOLE_PARITY_EN
    task automatic test_parity();
        logic s; bit ok; int ns;
        ns = start_q.size();
        exp_q.push_back(8'h07);
        exp_q.push_back(8'h03);
        bus_write(BASE, 4'b1000, 32'h07, s);
        bus_write(BASE, 4'b1000, 32'h03, s);
        wait_drain(200, ok);
        checks++;
        if (!ok || start_q.size() != ns + 2 || start_q[ns+1] - start_q[ns] != 45) begin
            errors++; $display("FAIL parity_frames: %0d frames, required 2 spaced 45 cycles", start_q.size() - ns);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_ignored();
        test_overflow();
        test_random();
        test_reset_abort();
`ifdef PHOENIX_CONSOLE_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
